// File: rtl/bp_be_thread_sched.sv
// Hardware-thread scheduler: owns the current thread ID and sequences each
// context switch as RUN -> DRAIN -> SWAP -> RUN (software CTXT or quantum preemption).
module bp_be_thread_sched #(
  parameter int num_threads_p     = 4,
  parameter int thread_id_width_p = $clog2(num_threads_p),
  parameter int quantum_width_p   = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         en_i,
  input  logic [quantum_width_p-1:0]   quantum_i,
  input  logic [num_threads_p-1:0]     thread_ready_i,
  input  logic                         csr_ctxt_write_v_i,
  input  logic [thread_id_width_p-1:0] csr_ctxt_write_data_i,
  output logic                         ctxt_reject_o,
  output logic                         drain_req_o,
  input  logic                         drained_i,
  output logic                         swap_v_o,
  output logic [thread_id_width_p-1:0] swap_old_id_o,
  output logic [thread_id_width_p-1:0] swap_new_id_o,
  input  logic                         swap_done_i,
  output logic [thread_id_width_p-1:0] current_thread_id_o,
  output logic                         busy_o,
  output logic [1:0]                   state_o
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] SWAP  = 2'd2;

  localparam logic [quantum_width_p-1:0] QONE = quantum_width_p'(1);

  logic [1:0]                   state_q, state_d;
  logic [thread_id_width_p-1:0] cur_q, cur_d;
  logic [thread_id_width_p-1:0] tgt_q, tgt_d;
  logic [quantum_width_p-1:0]   cnt_q, cnt_d;
  logic                         entry_q, entry_d;
  logic                         reject_q, reject_d;
  logic                         drain_q, swap_v_q, busy_q;

  logic                         rr_found;
  logic [thread_id_width_p-1:0] rr_id;
  logic [thread_id_width_p-1:0] cand;
  logic                         ctxt_valid;
  logic                         q_on;
  logic                         q_expired;

  // Descending scan so the nearest ready thread after current wins; the
  // power-of-two thread count makes the ID addition wrap naturally.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = cur_q;
    cand     = cur_q;
    for (int i = num_threads_p - 1; i >= 1; i--) begin
      cand = cur_q + thread_id_width_p'(i);
      if (thread_ready_i[cand]) begin
        rr_found = 1'b1;
        rr_id    = cand;
      end
    end
  end

  // Any ID that fits the port is in range because num_threads_p is a power of two.
  assign ctxt_valid = csr_ctxt_write_v_i
                    && (csr_ctxt_write_data_i != cur_q)
                    && thread_ready_i[csr_ctxt_write_data_i];

  // The first RUN cycle after a switch neither counts nor expires, so a slice
  // of quantum Q keeps the thread in RUN for Q+1 cycles.
  assign q_on      = en_i && (quantum_i != '0);
  assign q_expired = q_on && !entry_q && (cnt_q >= (quantum_i - QONE));

  // Swap handshake: swap_v_o is held with stable IDs until swap_done_i is
  // seen high in the same cycle; that cycle is the single transfer point.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    entry_d  = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      RUN: begin
        if (q_on && !entry_q && (cnt_q != '1)) cnt_d = cnt_q + QONE;
        reject_d = csr_ctxt_write_v_i && !ctxt_valid;
        if (ctxt_valid) begin
          tgt_d   = csr_ctxt_write_data_i;
          state_d = DRAIN;
        end else if (!thread_ready_i[cur_q] && rr_found) begin
          tgt_d   = rr_id;
          state_d = DRAIN;
        end else if (q_expired) begin
          if (rr_found) begin
            tgt_d   = rr_id;
            state_d = DRAIN;
          end else begin
            cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        reject_d = csr_ctxt_write_v_i;
        if (drained_i) state_d = SWAP;
      end
      SWAP: begin
        reject_d = csr_ctxt_write_v_i;
        if (swap_done_i) begin
          cur_d   = tgt_q;
          cnt_d   = '0;
          entry_d = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= RUN;
      cur_q    <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      entry_q  <= 1'b1;
      reject_q <= 1'b0;
      drain_q  <= 1'b0;
      swap_v_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      entry_q  <= entry_d;
      reject_q <= reject_d;
      drain_q  <= (state_d != RUN);
      swap_v_q <= (state_d == SWAP);
      busy_q   <= (state_d != RUN);
    end
  end

  assign ctxt_reject_o       = reject_q;
  assign drain_req_o         = drain_q;
  assign swap_v_o            = swap_v_q;
  assign busy_o              = busy_q;
  assign swap_old_id_o       = cur_q;
  assign swap_new_id_o       = tgt_q;
  assign current_thread_id_o = cur_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_bp_be_thread_sched.sv
// Directed bench for bp_be_thread_sched: swap handshakes and reject pulses are
// checked by a negedge monitor against expected queues; the rest inline.
module tb_bp_be_thread_sched;

  localparam int NT = 4;
  localparam int TW = 2;
  localparam int QW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [QW-1:0] quantum;
  logic [NT-1:0] ready;
  logic          csr_v;
  logic [TW-1:0] csr_data;
  logic          reject;
  logic          drain_req;
  logic          drained;
  logic          swap_v;
  logic [TW-1:0] old_id;
  logic [TW-1:0] new_id;
  logic          swap_done;
  logic [TW-1:0] cur;
  logic          busy;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;
  int n_drain;
  int n;

  logic [3:0] exp_q[$];
  logic [1:0] exp_rej_q[$];
  logic [3:0] mon_swap_e;
  logic [1:0] mon_rej_e;

  bp_be_thread_sched #(
    .num_threads_p(NT), .thread_id_width_p(TW), .quantum_width_p(QW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .quantum_i(quantum),
    .thread_ready_i(ready), .csr_ctxt_write_v_i(csr_v),
    .csr_ctxt_write_data_i(csr_data), .ctxt_reject_o(reject),
    .drain_req_o(drain_req), .drained_i(drained), .swap_v_o(swap_v),
    .swap_old_id_o(old_id), .swap_new_id_o(new_id), .swap_done_i(swap_done),
    .current_thread_id_o(cur), .busy_o(busy), .state_o(state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input int exp_cur);
    int k;
    k = 0;
    while (drain_req && k < 50) begin
      step();
      k++;
    end
    check("run_reached", drain_req, 0);
    check("run_thread", cur, exp_cur);
  endtask

  task automatic count_run(input int exp_len);
    int k;
    k = 0;
    while (!drain_req && k < 50) begin
      step();
      k++;
    end
    check("run_length", k, exp_len);
  endtask

  task automatic ctxt_write(input logic [TW-1:0] id);
    csr_v    = 1'b1;
    csr_data = id;
    step();
    csr_v    = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (swap_v && swap_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL swap_unexpected: old %0d new %0d with none expected", old_id, new_id);
        end else begin
          mon_swap_e = exp_q.pop_front();
          check("swap_ids", {old_id, new_id}, mon_swap_e);
        end
      end
      if (reject) begin
        if (exp_rej_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL reject_unexpected: reject with tgt %0d, none expected", new_id);
        end else begin
          mon_rej_e = exp_rej_q.pop_front();
          check("reject_tgt", new_id, mon_rej_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; quantum = '0; ready = '0;
    csr_v = 1'b0; csr_data = '0; drained = 1'b0; swap_done = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      en = 1'(($urandom_range(0, 1)));
      quantum = QW'($urandom_range(0, 65535));
      ready = NT'($urandom_range(0, 15));
      csr_v = 1'($urandom_range(0, 1));
      csr_data = TW'($urandom_range(0, 3));
      drained = 1'($urandom_range(0, 1));
      swap_done = 1'($urandom_range(0, 1));
      step();
      check("reset_outputs", {state, drain_req, swap_v, busy, reject, cur, new_id, old_id}, 0);
    end
    en = 1'b0; quantum = '0; ready = 4'b1111; csr_v = 1'b0; csr_data = '0;
    drained = 1'b1; swap_done = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    check("post_reset_state", state, 0);
    check("post_reset_thread", cur, 0);
    check("post_reset_drain", drain_req, 0);

    // software switch 0 -> 2, minimum latency
    exp_q.push_back({2'd0, 2'd2});
    ctxt_write(2'd2);
    check("sw_drain_t1", {drain_req, busy, swap_v}, 3'b110);
    step();
    check("sw_swap_t2", {drain_req, swap_v, old_id, new_id}, {2'b11, 2'd0, 2'd2});
    step();
    check("sw_run_t3", {drain_req, swap_v, busy, cur}, {3'b000, 2'd2});

    // quantum rotation over ready 0011 (current 2 not ready first)
    exp_q.push_back({2'd2, 2'd0});
    exp_q.push_back({2'd0, 2'd1});
    exp_q.push_back({2'd1, 2'd0});
    ready = 4'b0011; en = 1'b1; quantum = 16'd4;
    step();
    check("notready_drain", drain_req, 1);
    wait_run(0);
    count_run(5);
    wait_run(1);
    count_run(5);
    wait_run(0);
    en = 1'b0;

    // wrap: 3 -> 1 on expiry with ready 1010
    ready = 4'b1111;
    exp_q.push_back({2'd0, 2'd3});
    ctxt_write(2'd3);
    wait_run(3);
    exp_q.push_back({2'd3, 2'd1});
    ready = 4'b1010; en = 1'b1; quantum = 16'd4;
    count_run(5);
    wait_run(1);
    en = 1'b0;

    // skip: only current ready, expiry clears counter without switching
    exp_q.push_back({2'd1, 2'd3});
    ready = 4'b1000;
    step();
    check("skip_setup_drain", drain_req, 1);
    wait_run(3);
    step();
    en = 1'b1; quantum = 16'd4;
    n_drain = 0;
    repeat (9) begin
      step();
      if (drain_req) n_drain++;
    end
    check("skip_no_switch", n_drain, 0);
    exp_q.push_back({2'd3, 2'd1});
    ready = 4'b1010;
    n = 0;
    while (!drain_req && n < 20) begin
      step();
      n++;
    end
    check("expiry_after_clear", n, 3);
    wait_run(1);
    en = 1'b0;

    // rejects
    ready = 4'b1111;
    check("tgt_before_rejects", new_id, 1);
    exp_rej_q.push_back(2'd1);
    ctxt_write(2'd1);
    check("rej_self_pulse", {reject, drain_req}, 2'b10);
    step();
    check("rej_self_end", {reject, new_id}, {1'b0, 2'd1});
    ready = 4'b0011;
    exp_rej_q.push_back(2'd1);
    ctxt_write(2'd3);
    check("rej_notready_pulse", {reject, drain_req}, 2'b10);
    step();
    check("rej_notready_end", {reject, new_id}, {1'b0, 2'd1});

    ready = 4'b1111; drained = 1'b0; swap_done = 1'b0;
    ctxt_write(2'd3);
    check("drain_entry", {drain_req, reject, new_id}, {2'b10, 2'd3});
    step();
    exp_rej_q.push_back(2'd3);
    ctxt_write(2'd0);
    check("rej_drain_pulse", reject, 1);
    step();
    check("rej_drain_end", reject, 0);
    step();
    check("drain_hold", {drain_req, swap_v, new_id}, {2'b10, 2'd3});

    // handshake stall, then reset mid-swap
    drained = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", {swap_v, drain_req, busy, old_id, new_id}, {3'b111, 2'd1, 2'd3});
      step();
    end
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_mid_swap", {state, drain_req, swap_v, busy, reject, cur, new_id}, 0);
    swap_done = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    step();
    check("after_reset_run", {state, cur, drain_req}, 0);

    check("swap_queue_empty", exp_q.size(), 0);
    check("reject_queue_empty", exp_rej_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
